// File: rtl/surf_merger_n.sv
// surf_merger_n: gathers one byte from every enabled channel, then emits the lane-aligned
// word as NCHAN*8/OUT_W output beats. Optional event header: `define SURF_MERGER_HEADER_EN.
module surf_merger_n #(
  parameter int         NCHAN     = 8,
  parameter int         OUT_W     = 32,
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NCHAN-1:0]     en_mask_i,
  input  logic [NCHAN*8-1:0]   s_axis_tdata,
  input  logic [NCHAN-1:0]     s_axis_tvalid,
  output logic [NCHAN-1:0]     s_axis_tready,
  input  logic [NCHAN-1:0]     s_axis_tlast,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 mismatch_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [2:0]           dbg_state
);

  localparam int NW = NCHAN * 8 / OUT_W;
  localparam int SW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(NW - 1);

  if (OUT_W % 8 != 0 || (NCHAN * 8) % OUT_W != 0 || NCHAN < 1 || NCHAN > 16) begin : g_bad_cfg
    $fatal(1, "surf_merger_n: illegal NCHAN/OUT_W combination");
  end
`ifdef SURF_MERGER_HEADER_EN
  if (OUT_W <= NCHAN) begin : g_bad_hdr
    $fatal(1, "surf_merger_n: header needs OUT_W > NCHAN");
  end
`endif

  // Handshakes: a beat moves on the rising aclk edge where valid and ready are both high;
  // tready here depends only on registered state, and output data/valid/last hold while stalled.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATHER = 3'd1,
    S_EMIT   = 3'd2,
    S_FLUSH  = 3'd3
`ifdef SURF_MERGER_HEADER_EN
    , S_HDR  = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [NCHAN-1:0]       emask_q, full_q, last_q, wlast_q, drain_q;
  logic [NCHAN*8-1:0]     byte_q, word_q;
  logic [SW-1:0]          slice_q;
  logic [ERR_CNT_W-1:0]   err_q;
`ifdef SURF_MERGER_HEADER_EN
  logic [OUT_W-NCHAN-1:0] evt_q;
`endif

  logic [NCHAN-1:0]   in_hs, full_n, last_n;
  logic [NCHAN*8-1:0] byte_n, fill_word;
  logic               all_full, all_last, any_last, final_slice, out_hs;

  assign in_hs       = s_axis_tvalid & s_axis_tready;
  assign full_n      = full_q | in_hs;
  assign all_full    = &(full_n | ~emask_q);
  assign all_last    = &(wlast_q | ~emask_q);
  assign any_last    = |(wlast_q & emask_q);
  assign final_slice = (slice_q == LAST_SLICE);
  assign out_hs      = m_axis_tvalid & m_axis_tready;
  assign err_cnt_o   = err_q;
  assign dbg_state   = state_q;

  // Bytes accepted this cycle are merged in so the word can be loaded on the last handshake.
  always_comb begin
    byte_n    = byte_q;
    last_n    = last_q;
    fill_word = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (in_hs[k]) begin
        byte_n[8*k +: 8] = s_axis_tdata[8*k +: 8];
        last_n[k]        = s_axis_tlast[k];
      end
      fill_word[8*k +: 8] = emask_q[k] ? byte_n[8*k +: 8] : FILL_BYTE;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = word_q[slice_q*OUT_W +: OUT_W];
    mismatch_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|(en_mask_i & s_axis_tvalid)) begin
`ifdef SURF_MERGER_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_GATHER;
`endif
        end
      end
`ifdef SURF_MERGER_HEADER_EN
      S_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {evt_q, emask_q};
        if (m_axis_tready) state_d = S_GATHER;
      end
`endif
      S_GATHER: begin
        s_axis_tready = emask_q & ~full_q;
        if (all_full) state_d = S_EMIT;
      end
      S_EMIT: begin
        m_axis_tvalid = 1'b1;
        if (final_slice) m_axis_tlast = any_last;
        if (out_hs && final_slice) begin
          if (all_last) begin
            state_d = S_IDLE;
          end else if (!any_last) begin
            state_d = S_GATHER;
          end else begin
            mismatch_o = 1'b1;
            state_d    = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        s_axis_tready = drain_q;
        if (drain_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      emask_q <= '0;
      full_q  <= '0;
      last_q  <= '0;
      wlast_q <= '0;
      drain_q <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      slice_q <= '0;
      err_q   <= '0;
`ifdef SURF_MERGER_HEADER_EN
      evt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          slice_q <= '0;
          if (state_d != S_IDLE) emask_q <= en_mask_i;
        end
`ifdef SURF_MERGER_HEADER_EN
        S_HDR: if (out_hs) evt_q <= evt_q + 1'b1;
`endif
        S_GATHER: begin
          byte_q <= byte_n;
          last_q <= last_n;
          if (all_full) begin
            word_q  <= fill_word;
            wlast_q <= last_n;
            drain_q <= emask_q & ~last_n;
            full_q  <= '0;
            slice_q <= '0;
          end else begin
            full_q <= full_n;
          end
        end
        S_EMIT: begin
          if (out_hs) slice_q <= final_slice ? '0 : slice_q + 1'b1;
          if (mismatch_o && err_q != {ERR_CNT_W{1'b1}}) err_q <= err_q + 1'b1;
        end
        S_FLUSH: drain_q <= drain_q & ~(in_hs & s_axis_tlast);
        default: ;
      endcase
    end
  end

endmodule
